div_seq: RTL

Sequential 16-by-8 unsigned restoring divider, the inverse companion of the team's sequential 8×8 multiplier `pr`. It uses the same start/ready handshake, so a 16-bit product from the multiplier can be fed straight back and checked. One quotient bit is resolved per clock: 16 iteration cycles per operation. It sits beside `pr` in the arithmetic lab designs and is driven by a bench or a simple controller.

---
 rtl/div_pkg.sv | 9 +
 rtl/div_step.sv | 28 ++
 rtl/div_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths and state type for the
// sequential restoring divider.
package div_pkg;
  localparam int NW = 16;
  localparam int DW = 8;
  localparam int CW = $clog2(NW);

  typedef enum logic {IDLE, CALC} div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step:
// shift in a dividend bit, trial-subtract, restore.
module div_step
  import div_pkg::*;
(
  input  logic [DW:0]   pr,
  input  logic [DW-1:0] d,
  input  logic          bin,
  output logic [DW:0]   pr_next,
  output logic          qbit
);

  logic [DW:0] t;
  logic [DW:0] diff;
  logic        unused_msb;

  // pr stays below d after every step, so its MSB never carries data
  assign unused_msb = pr[DW];

  // trial subtraction in DW+1 bits, keep t when it would go negative
  always_comb begin
    t       = {pr[DW-1:0], bin};
    diff    = t - {1'b0, d};
    qbit    = (t >= {1'b0, d});
    pr_next = qbit ? diff : t;
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 16/8 unsigned restoring divider,
// one quotient bit per clock, start/ready handshake.
module div_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          ready,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          dz
);

  div_state_t    state;
  div_state_t    state_nx;
  logic [NW-1:0] nreg;
  logic [DW-1:0] dreg;
  logic [DW:0]   pr;
  logic [DW:0]   pr_nx;
  logic [CW-1:0] cnt;
  logic          qbit;
  logic [NW-1:0] q_nx;
  logic          last;

  div_step u_step (
    .pr      (pr),
    .d       (dreg),
    .bin     (nreg[NW-1]),
    .pr_next (pr_nx),
    .qbit    (qbit)
  );

  assign q_nx = {nreg[NW-2:0], qbit};
  assign last = (cnt == '0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and handshake output
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nreg <= '0;
      dreg <= '0;
      pr   <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            nreg <= n;
            dreg <= d;
            pr   <= '0;
            cnt  <= CW'(NW - 1);
          end
        end
        CALC: begin
          nreg <= q_nx;
          pr   <= pr_nx;
          cnt  <= cnt - 1'b1;
          if (last) begin
            q  <= (dreg == '0) ? '1 : q_nx;
            r  <= pr_nx[DW-1:0];
            dz <= (dreg == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
